// File: rtl/j_power_stim_ctrl_if.sv
// Stimulus/result bus between the power-stimulus controller and its driver.
// The slave modport is the controller side; master is the driver/array side.
interface j_power_stim_ctrl_if #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_WIDTH = 32
);
  localparam int W = NUM_LANES * LANE_WIDTH;

  logic                 start;
  logic [1:0]           mode;
  logic [15:0]          run_len;
  logic [W-1:0]         stim_data;
  logic                 stim_valid;
  logic [W-1:0]         result_in;
  logic [NUM_LANES-1:0] result_en_in;
  logic                 result_xor;
  logic                 result_en_xor;
  logic                 busy;
  logic                 done;
  logic [15:0]          cycle_count;

  modport master (
    output start, mode, run_len, result_in, result_en_in,
    input  stim_data, stim_valid, result_xor, result_en_xor, busy, done, cycle_count
  );

  modport slave (
    input  start, mode, run_len, result_in, result_en_in,
    output stim_data, stim_valid, result_xor, result_en_xor, busy, done, cycle_count
  );
endinterface

// File: rtl/j_power_stim_ctrl.sv
// Drives run_len cycles of a chosen activity pattern into an array, then drains results for DRAIN_CYCLES.
// Stimulus and result reductions are registered (1-cycle latency); start is only honoured in IDLE.
module j_power_stim_ctrl #(
  parameter int          NUM_LANES    = 8,
  parameter int          LANE_WIDTH   = 32,
  parameter int          DRAIN_CYCLES = 64,
  parameter logic [31:0] SEED         = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              reset,
  j_power_stim_ctrl_if.slave bus
);
  localparam int          W          = NUM_LANES * LANE_WIDTH;
  localparam logic [31:0] TAPS       = 32'h8020_0003;
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic        accept, run_last;
  logic [1:0]  mode_q;
  logic [15:0] run_len_q;
  logic [15:0] drain_cnt;
  logic [15:0] cycle_count;
  logic [W-1:0] stim_data, stim_first, stim_step;
  logic        result_xor, result_en_xor, result_xor_d;
  logic [31:0] lfsr      [NUM_LANES];
  logic [31:0] lfsr_seed [NUM_LANES];
  logic [31:0] lfsr_step [NUM_LANES];

  function automatic logic [31:0] galois_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Per-lane seeds are spread with the golden-ratio constant so lanes decorrelate.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [31:0] MIX = SEED ^ (32'(g) * 32'h9E37_79B9);
    assign lfsr_seed[g] = (MIX == 32'h0) ? 32'h1 : MIX;
    assign lfsr_step[g] = galois_step(lfsr[g]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    run_last   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (bus.run_len != 16'd0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (cycle_count == run_len_q - 16'd1) begin
          run_last   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // First pattern uses the live mode (the cycle of acceptance); later steps use the latched mode.
  always_comb begin
    stim_first = '0;
    stim_step  = '0;
    case (bus.mode)
      2'b01: stim_first = '1;
      2'b10: for (int l = 0; l < NUM_LANES; l++)
               stim_first[l*LANE_WIDTH +: LANE_WIDTH] = lfsr_seed[l][LANE_WIDTH-1:0];
      2'b11: stim_first = W'(1);
      default: stim_first = '0;
    endcase
    case (mode_q)
      2'b01: stim_step = ~stim_data;
      2'b10: for (int l = 0; l < NUM_LANES; l++)
               stim_step[l*LANE_WIDTH +: LANE_WIDTH] = lfsr_step[l][LANE_WIDTH-1:0];
      2'b11: stim_step = (stim_data << 1) | (stim_data >> (W - 1));
      default: stim_step = '0;
    endcase
  end

  always_comb begin
    result_xor_d = 1'b0;
    for (int l = 0; l < NUM_LANES; l++)
      if (bus.result_en_in[l])
        result_xor_d = result_xor_d ^ (^bus.result_in[l*LANE_WIDTH +: LANE_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stim_data     <= '0;
      mode_q        <= 2'b00;
      run_len_q     <= 16'd0;
      cycle_count   <= 16'd0;
      drain_cnt     <= 16'd0;
      result_xor    <= 1'b0;
      result_en_xor <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) lfsr[l] <= lfsr_seed[l];
    end else begin
      result_xor    <= result_xor_d;
      result_en_xor <= |bus.result_en_in;
      if (accept) begin
        mode_q      <= bus.mode;
        run_len_q   <= bus.run_len;
        cycle_count <= 16'd0;
        drain_cnt   <= 16'd0;
        stim_data   <= (bus.run_len != 16'd0) ? stim_first : '0;
        for (int l = 0; l < NUM_LANES; l++) lfsr[l] <= lfsr_seed[l];
      end else if (state == RUN) begin
        cycle_count <= (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        stim_data   <= run_last ? '0 : stim_step;
        for (int l = 0; l < NUM_LANES; l++) lfsr[l] <= lfsr_step[l];
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 16'd1;
      end
    end
  end

  assign bus.stim_data     = stim_data;
  assign bus.stim_valid    = (state == RUN);
  assign bus.busy          = (state == RUN) || (state == DRAIN);
  assign bus.done          = (state == DONE);
  assign bus.cycle_count   = cycle_count;
  assign bus.result_xor    = result_xor;
  assign bus.result_en_xor = result_en_xor;
endmodule

// File: doc/j_power_stim_ctrl.md
J_POWER_STIM_CTRL -- requirements
Module: j_power_stim_ctrl

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 8, number of stimulus/result lanes driven into the array under test.
REQ-002 SHALL provide parameter LANE_WIDTH, default 32, bits per lane; legal range 1..32.
REQ-003 SHALL provide parameter DRAIN_CYCLES, default 64, cycles of result collection after stimulus ends; legal range 1..65535.
REQ-004 SHALL provide parameter SEED, default 32'hACE1_2468, non-zero LFSR base seed.
REQ-005 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide start  input  1  run request, sampled only in IDLE.
REQ-008 SHALL provide mode  input  2  activity pattern: 00 idle-zero, 01 max-toggle, 10 LFSR-random, 11 walking-one.
REQ-009 SHALL provide run_len  input  16  number of stimulus cycles per run.
REQ-010 SHALL provide stim_data  output  NUM_LANES*LANE_WIDTH  registered stimulus; lane l occupies bits [l*LANE_WIDTH +: LANE_WIDTH].
REQ-011 SHALL provide stim_valid  output  1  stimulus qualifier.
REQ-012 SHALL provide result_in  input  NUM_LANES*LANE_WIDTH  results returned from the array, same lane packing.
REQ-013 SHALL provide result_en_in  input  NUM_LANES  per-lane result valid.
REQ-014 SHALL provide result_xor  output  1  registered XOR reduction of enabled result lanes.
REQ-015 SHALL provide result_en_xor  output  1  registered OR of result_en_in.
REQ-016 SHALL provide busy  output  1, done  output  1, cycle_count  output  16  (stimulus cycles issued in current/last run).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 SHALL latch mode and run_len, clear cycle_count, go to RUN if run_len!=0, else DRAIN.
REQ-019 RUN: SHALL assert stim_valid for exactly run_len consecutive cycles, first one the cycle after start accepted; cycle_count increments once per stim_valid cycle.
REQ-020 RUN->DRAIN SHALL occur after the run_len-th stimulus cycle; DRAIN SHALL last exactly DRAIN_CYCLES cycles, then DONE.
REQ-021 DONE SHALL last one cycle with done=1, then IDLE; busy=1 in RUN and DRAIN only.
REQ-022 start while not IDLE SHALL be ignored; mode/run_len changes mid-run SHALL have no effect.
REQ-023 stim_data SHALL be all-zero whenever stim_valid=0.
REQ-024 mode 00: stim_data SHALL be zero while stim_valid=1 (static-power baseline).
REQ-025 mode 01: stim_data SHALL be all-ones on stimulus cycle 0, then invert every cycle.
REQ-026 mode 10: each lane l SHALL own a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded at start with SEED ^ (l*32'h9E3779B9), replaced by 32'h1 if that is zero; lane data = low LANE_WIDTH bits of the seed on cycle 0, LFSR advances one step per stimulus cycle.
REQ-027 mode 11: stim_data SHALL be one-hot at bit 0 on cycle 0, position advancing by one per cycle, wrapping from bit NUM_LANES*LANE_WIDTH-1 to 0.
REQ-028 result_xor SHALL, every cycle in every state, equal XOR of all bits of lanes with result_en_in[l]=1 from the previous cycle (0 if none); latency 1.
REQ-029 result_en_xor SHALL equal previous-cycle OR of result_en_in; latency 1.
REQ-030 cycle_count SHALL hold its final value through DRAIN, DONE and IDLE until the next accepted start; it SHALL saturate at 16'hFFFF.

Reset
REQ-031 reset=1 SHALL force IDLE, stim_data=0, stim_valid=0, result_xor=0, result_en_xor=0, busy=0, done=0, cycle_count=0, LFSRs to seed values, on the next rising edge.
REQ-032 reset SHALL take priority over start and over any in-progress RUN/DRAIN; no done pulse is produced for an aborted run.

Verification
REQ-033 mode=01, run_len=4, DRAIN_CYCLES=2, start pulse -> stim_valid 4 cycles, data FF..,00..,FF..,00..; done pulses 7 cycles after start edge; cycle_count=4.
REQ-034 mode=11, NUM_LANES=2, LANE_WIDTH=4, run_len=10 -> one-hot bits 0..7 then 0,1; stim_data=0 after run.
REQ-035 run_len=0, start -> no stim_valid, busy for DRAIN_CYCLES, done pulse, cycle_count=0.
REQ-036 result_en_in=8'b0000_0011, lane0=32'h1, lane1=32'h3 -> result_xor=1 one cycle later; result_en_in=0 -> result_xor=0, result_en_xor=0.
REQ-037 mode=10, run_len=100, reset asserted at stimulus cycle 50 -> all outputs zero next cycle, no done; restart reproduces identical first 50 stim_data words.
REQ-038 start re-pulsed during RUN with different mode -> ignored; pattern and run length unchanged.
